adc_sli_deser: RTL and testbench
================================

// Module: adc_sli_deser
// PURPOSE
// Parametrised successor to the fixed 32->16 ADC slicer. Accepts packed ADC words (LANES samples/word) on an AXI-Stream
// slave with backpressure, buffers them in an inferred word FIFO and emits one sample/cycle on a ready/valid master
// with chirp sop/eop, frame sop/eop and chirp index. Any sample_num that is a LANES multiple is supported; store-and-forward
// or cut-through is selectable. Length and overflow errors are flagged. Sits between the ADC capture AXIS and range FFT.
// PARAMETERS
// SAMPLE_W     16    bits per sample
// LANES        2     samples per input word (power of 2, >=2)
// MAX_SAMPLES  4096  largest legal sample_num
// FIFO_DEPTH   2048  word FIFO depth (power of 2; >= MAX_SAMPLES/LANES when STORE_FWD=1)
// STORE_FWD    1     1: chirp output starts only once whole chirp buffered; 0: cut-through
// MSB_FIRST    1     1: highest lane emitted first; 0: lane 0 (LSBs) first
// PORTS
// clk            in   1                 clock
// rst_n          in   1                 async reset, active low
// s_axis_tdata   in   LANES*SAMPLE_W    packed samples
// s_axis_tvalid  in   1                 input word valid
// s_axis_tlast   in   1                 last word of chirp
// s_axis_tready  out  1                 !fifo_full
// sample_num     in   16                samples per chirp
// chirp_num      in   16                chirps per frame
// m_data         out  SAMPLE_W          output sample
// m_valid        out  1                 output valid
// m_ready        in   1                 downstream accept
// m_sop / m_eop  out  1                 first / last sample of chirp (qualified by m_valid)
// m_frame_sop    out  1                 first sample of chirp 0
// m_frame_eop    out  1                 last sample of chirp chirp_num-1
// m_chirp_idx    out  16                chirp index of current sample
// len_err        out  1                 1-cycle pulse: tlast position mismatch
// ovf_err        out  1                 1-cycle pulse: tvalid while !tready
// cfg_err        out  1                 1-cycle pulse: illegal sample_num latched
// BEHAVIOUR
// - Reset: all outputs 0 except s_axis_tready=1 after reset released; FIFO empty, all counters 0. Reset mid-chirp drops data.
// - Write: word accepted when tvalid&&tready; stored with tag last=(wr_cnt==words-1), words=sample_num/LANES.
// - sample_num latched at first word of each chirp (wr_cnt==0). Illegal (0, >MAX_SAMPLES, not LANES multiple): cfg_err,
//   chirp's words accepted and discarded until tlast.
// - tlast early (wr_cnt<words-1) or missing at wr_cnt==words-1: len_err; word tagged last either way, wr_cnt->0 on tag or tlast.
// - Store-fwd: complete-chirp counter ++ on write of tagged word, -- on read of tagged word; reader starts a chirp only if >0.
//   Simultaneous ++/-- leaves counter unchanged.
// - Read FSM: IDLE -> (head available) LOAD -> EMIT; EMIT steps lane counter on each output accept; after final lane pops
//   word; next word loaded without bubble if available, else m_valid drops (cut-through) until data arrives.
// - Output register advances when m_ready||!m_valid; m_data/flags held stable while m_valid&&!m_ready.
// - Latency: word accepted at edge N -> earliest m_valid at edge N+2 (cut-through, FIFO previously empty).
// - m_sop on lane 0-order first sample of chirp; m_eop on final sample of tagged word. Throughput 1 sample/clk with m_ready=1.
// - chirp_num latched at m_frame_sop; m_chirp_idx ++ after m_eop, wraps to 0 after chirp_num-1 (chirp_num=0 treated as 1).
// - Full: tready=0; a read and write in same cycle at full is allowed (write accepted only if read pops that cycle is NOT
//   assumed: tready is registered-free combinational !full). Empty: no read; simultaneous write+read at empty is not a hit.
// TESTING
// 1 LANES=2,sample_num=1024,STORE_FWD=1,m_ready=1: 512 words 0x0001_0000.. -> first m_valid after 512th word, 1024 samples
//   MSB-first 0x0001,0x0000,..., m_sop on sample 0, m_eop on 1023, no gaps.
// 2 sample_num=6 (LANES=2),chirp_num=3, 9 words, cut-through -> m_chirp_idx 0,1,2, frame_sop on idx0 s0, frame_eop idx2 s5.
// 3 tlast on word 100 of 512 -> len_err 1 cycle, chirp ends with m_eop after sample 201, next chirp m_sop on fresh data.
// 4 m_ready toggling 1/0 random, 4096 samples -> output sequence identical to m_ready=1 case, data stable during stall.
// 5 FIFO_DEPTH=16, m_ready=0, push 20 words -> tready falls after 16, ovf_err pulses per extra tvalid cycle, no corruption.
// 6 sample_num=1023 -> cfg_err, no output; rst_n low mid-chirp -> all outputs 0 asynchronously, next chirp clean.

Source files
------------

// File: rtl/adc_sli_deser.sv
// adc_sli_deser: packed ADC word stream -> one sample per clock, chirp/frame framing.
// Ports: s_axis_* word input (tready = !full), sample_num/chirp_num config,
//   m_* sample output with ready/valid, sop/eop, frame sop/eop, chirp index,
//   len_err/ovf_err/cfg_err single-cycle error pulses.
module adc_sli_deser #(
    parameter int SAMPLE_W    = 16,
    parameter int LANES       = 2,
    parameter int MAX_SAMPLES = 4096,
    parameter int FIFO_DEPTH  = 2048,
    parameter int STORE_FWD   = 1,
    parameter int MSB_FIRST   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    input  logic [15:0]               sample_num,
    input  logic [15:0]               chirp_num,
    output logic [SAMPLE_W-1:0]       m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_sop,
    output logic                      m_eop,
    output logic                      m_frame_sop,
    output logic                      m_frame_eop,
    output logic [15:0]               m_chirp_idx,
    output logic                      len_err,
    output logic                      ovf_err,
    output logic                      cfg_err
);
    localparam int WW = LANES * SAMPLE_W;
    localparam int LB = $clog2(LANES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LB-1:0] LMAX = LB'(LANES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} st_t;

    // word FIFO, MSB of each entry is the chirp-end tag
    logic [WW:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign s_axis_tready = !full;

    // ---------------- write side ----------------
    logic [15:0] wr_cnt_q, wr_cnt_d, words_q, words_new, words_eff;
    logic        drop_q, drop_d;
    logic        acc, sn_ok, first, bad, store, at_end, tag;
    logic        len_err_q, ovf_err_q, cfg_err_q;

    always_comb begin
        acc       = s_axis_tvalid && s_axis_tready;
        sn_ok     = (sample_num != 16'd0) &&
                    ({16'd0, sample_num} <= 32'(MAX_SAMPLES)) &&
                    (sample_num[LB-1:0] == '0);
        words_new = sample_num >> LB;
        first     = (wr_cnt_q == 16'd0) && !drop_q;
        bad       = first && !sn_ok;
        words_eff = first ? words_new : words_q;
        at_end    = (wr_cnt_q == 16'(words_eff - 16'd1));
        tag       = at_end || s_axis_tlast;
        store     = acc && !drop_q && !bad;
        wr_cnt_d  = wr_cnt_q;
        drop_d    = drop_q;
        if (acc) begin
            // an illegal chirp is swallowed up to and including its tlast
            if (drop_q || bad) drop_d = !s_axis_tlast;
            else wr_cnt_d = tag ? 16'd0 : 16'(wr_cnt_q + 16'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            wr_cnt_q  <= '0;
            words_q   <= '0;
            drop_q    <= 1'b0;
            len_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            drop_q    <= drop_d;
            len_err_q <= store && (s_axis_tlast != at_end);
            cfg_err_q <= acc && bad;
            ovf_err_q <= s_axis_tvalid && !s_axis_tready;
            if (store) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                if (first) words_q <= words_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q[AW-1:0]] <= {tag, s_axis_tdata};
    end

    assign len_err = len_err_q;
    assign ovf_err = ovf_err_q;
    assign cfg_err = cfg_err_q;

    // ---------------- read side ----------------
    st_t           state_q;
    logic [WW:0]   head;
    logic [LB-1:0] nl_q, phys;
    logic [AW:0]   cc_q, cc_d;
    logic          start_q, avail, adv, ld, pop, stop, last_lane;
    logic          sop_n, eop_n, fsop_n, feop_n;
    logic [15:0]   idx_q, cn_q, cn_last;
    logic [SAMPLE_W-1:0] m_data_q;
    logic          m_valid_q, m_sop_q, m_eop_q, m_fsop_q, m_feop_q;
    logic [15:0]   m_idx_q;

    always_comb begin
        head      = mem_q[rd_ptr_q[AW-1:0]];
        last_lane = (nl_q == LMAX);
        phys      = (MSB_FIRST != 0) ? LMAX - nl_q : nl_q;
        // store-and-forward holds a chirp start until a whole chirp is queued
        avail     = !empty && ((STORE_FWD == 0) || !start_q || (cc_q != '0));
        adv       = m_ready || !m_valid_q;
        ld        = (state_q == LOAD) ||
                    ((state_q == EMIT) && adv && ((nl_q != '0) || avail));
        pop       = ld && last_lane;
        stop      = (state_q == EMIT) && adv && (nl_q == '0) && !avail;
        cn_last   = (cn_q == 16'd0) ? 16'd0 : 16'(cn_q - 16'd1);
        sop_n     = start_q && (nl_q == '0);
        eop_n     = last_lane && head[WW];
        fsop_n    = sop_n && (idx_q == 16'd0);
        feop_n    = eop_n && (idx_q == cn_last);
        cc_d      = cc_q + (AW+1)'(store && tag) - (AW+1)'(pop && head[WW]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cc_q <= '0;
        else        cc_q <= cc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            nl_q      <= '0;
            start_q   <= 1'b1;
            idx_q     <= '0;
            cn_q      <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_sop_q   <= 1'b0;
            m_eop_q   <= 1'b0;
            m_fsop_q  <= 1'b0;
            m_feop_q  <= 1'b0;
            m_idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE:    if (avail) state_q <= LOAD;
                LOAD:    state_q <= EMIT;
                EMIT:    if (stop) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (ld) begin
                m_data_q  <= head[int'(phys)*SAMPLE_W +: SAMPLE_W];
                m_valid_q <= 1'b1;
                m_sop_q   <= sop_n;
                m_eop_q   <= eop_n;
                m_fsop_q  <= fsop_n;
                m_feop_q  <= feop_n;
                m_idx_q   <= idx_q;
                nl_q      <= last_lane ? '0 : nl_q + LB'(1);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                    start_q  <= head[WW];
                end
                if (fsop_n) cn_q <= chirp_num;
                if (eop_n) idx_q <= (idx_q == cn_last) ? 16'd0 : 16'(idx_q + 16'd1);
            end else if (stop) begin
                m_valid_q <= 1'b0;
                m_sop_q   <= 1'b0;
                m_eop_q   <= 1'b0;
                m_fsop_q  <= 1'b0;
                m_feop_q  <= 1'b0;
            end
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_sop       = m_sop_q;
    assign m_eop       = m_eop_q;
    assign m_frame_sop = m_fsop_q;
    assign m_frame_eop = m_feop_q;
    assign m_chirp_idx = m_idx_q;
endmodule

// File: tb/tb_adc_sli_deser.sv
// tb_adc_sli_deser: directed bench for adc_sli_deser (LANES=2, depth 16,
//   store-and-forward, MSB first, MAX_SAMPLES=32).
module tb_adc_sli_deser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tdata;
    logic        tvalid, tlast, tready;
    logic [15:0] sample_num, chirp_num;
    logic [15:0] m_data;
    logic        m_valid, m_ready, m_sop, m_eop, m_frame_sop, m_frame_eop;
    logic [15:0] m_chirp_idx;
    logic        len_err, ovf_err, cfg_err;
    logic        rdy_fix, rdy_rnd = 1'b1, rnd_en;

    always #5 clk = ~clk;
    assign m_ready = rnd_en ? rdy_rnd : rdy_fix;
    always @(posedge clk) rdy_rnd <= 1'($urandom_range(1, 0));

    adc_sli_deser #(
        .SAMPLE_W(16), .LANES(2), .MAX_SAMPLES(32),
        .FIFO_DEPTH(16), .STORE_FWD(1), .MSB_FIRST(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(tready),
        .sample_num(sample_num), .chirp_num(chirp_num),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop),
        .m_frame_sop(m_frame_sop), .m_frame_eop(m_frame_eop),
        .m_chirp_idx(m_chirp_idx),
        .len_err(len_err), .ovf_err(ovf_err), .cfg_err(cfg_err)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  f;
        logic [15:0] ix;
        logic [31:0] c;
    } smp_t;

    smp_t oq[$];
    int   cyc = 0;
    int   vcnt = 0, lcnt = 0, ocnt = 0, ccnt = 0, viol = 0;
    logic stall_q = 1'b0;
    logic [15:0] hd = '0;
    logic [3:0]  hf = '0;
    int   vectors = 0, errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // output monitor: logs accepted samples, error pulses, stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready)
                oq.push_back('{m_data, {m_sop, m_eop, m_frame_sop, m_frame_eop},
                               m_chirp_idx, 32'(cyc)});
            if (m_valid) vcnt <= vcnt + 1;
            if (len_err) lcnt <= lcnt + 1;
            if (ovf_err) ocnt <= ocnt + 1;
            if (cfg_err) ccnt <= ccnt + 1;
            if (stall_q && !(m_valid && m_data == hd &&
                {m_sop, m_eop, m_frame_sop, m_frame_eop} == hf))
                viol <= viol + 1;
            stall_q <= m_valid && !m_ready;
            hd      <= m_data;
            hf      <= {m_sop, m_eop, m_frame_sop, m_frame_eop};
        end else begin
            stall_q <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        logic ok;
        int   g;
        tdata = d; tlast = l; tvalid = 1'b1; ok = 1'b0; g = 0;
        while (!ok && g < 100) begin
            @(negedge clk);
            ok = tready;
            @(posedge clk);
            #1;
            g++;
        end
        tvalid = 1'b0; tlast = 1'b0;
        if (!ok) chk("push_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_n(input int n, input string tag);
        int g = 0;
        while (oq.size() < n && g < 500) begin
            tick(1);
            g++;
        end
        tick(3);
        chk(tag, 32'(oq.size()), 32'(n));
    endtask

    function automatic logic [31:0] wd(input logic [15:0] b, input int w);
        return {16'(b + 16'(2*w + 1)), 16'(b + 16'(2*w))};
    endfunction

    int base, v0, l0, o0, c0, cstart;

    initial begin
        tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        sample_num = 16'd8; chirp_num = 16'd1;
        rdy_fix = 1'b1; rnd_en = 1'b0;
        tick(3);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_flags", 32'({m_sop, m_eop, m_frame_sop, m_frame_eop,
                              len_err, ovf_err, cfg_err}), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("rst_tready", 32'(tready), 32'd1);

        // store-and-forward: nothing until chirp complete, then N+2 latency
        base = oq.size(); v0 = vcnt;
        for (int w = 0; w < 3; w++) push(wd(16'h0000, w), 1'b0);
        tick(6);
        chk("sf_hold", 32'(vcnt - v0), 32'd0);
        push(wd(16'h0000, 3), 1'b1);
        cstart = cyc;
        wait_n(base + 8, "t1_count");
        chk("t1_latency", 32'(int'(oq[base].c) - cstart), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t1_data", 32'(oq[base+i].d), 32'(i ^ 1));
            chk("t1_flags", 32'(oq[base+i].f), 32'({i == 0, i == 7, i == 0, i == 7}));
            chk("t1_nogap", oq[base+i].c - oq[base].c, 32'(i));
        end

        // frame of 3 chirps x 6 samples
        chirp_num = 16'd3; sample_num = 16'd6;
        base = oq.size();
        for (int w = 0; w < 9; w++) push(wd(16'h0100, w), w % 3 == 2);
        wait_n(base + 18, "t2_count");
        for (int i = 0; i < 18; i++) begin
            chk("t2_data", 32'(oq[base+i].d), 32'(16'h0100 + 16'(i ^ 1)));
            chk("t2_flags", 32'(oq[base+i].f),
                32'({i % 6 == 0, i % 6 == 5, i == 0, i == 17}));
            chk("t2_idx", 32'(oq[base+i].ix), 32'(i / 6));
        end

        // early tlast, missing tlast, then a clean chirp
        chirp_num = 16'd1; sample_num = 16'd8;
        base = oq.size(); l0 = lcnt;
        push(wd(16'h0200, 0), 1'b0);
        push(wd(16'h0200, 1), 1'b1);
        sample_num = 16'd4;
        push(wd(16'h0200, 2), 1'b0);
        push(wd(16'h0200, 3), 1'b0);
        push(wd(16'h0200, 4), 1'b0);
        push(wd(16'h0200, 5), 1'b1);
        wait_n(base + 12, "t3_count");
        chk("t3_len_err", 32'(lcnt - l0), 32'd2);
        for (int i = 0; i < 12; i++) begin
            chk("t3_data", 32'(oq[base+i].d), 32'(16'h0200 + 16'(i ^ 1)));
            chk("t3_flags", 32'(oq[base+i].f),
                32'({i % 4 == 0, i % 4 == 3, i % 4 == 0, i % 4 == 3}));
        end

        // random backpressure
        sample_num = 16'd16;
        base = oq.size();
        rnd_en = 1'b1;
        for (int w = 0; w < 8; w++) push(wd(16'h0300, w), w == 7);
        wait_n(base + 16, "t4_count");
        rnd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t4_data", 32'(oq[base+i].d), 32'(16'h0300 + 16'(i ^ 1)));
            chk("t4_flags", 32'(oq[base+i].f),
                32'({i == 0, i == 15, i == 0, i == 15}));
        end
        chk("t4_stable", 32'(viol), 32'd0);

        // fill FIFO with output stalled, then overflow attempts
        rdy_fix = 1'b0; sample_num = 16'd32;
        base = oq.size(); o0 = ocnt;
        for (int w = 0; w < 16; w++) push(wd(16'h0400, w), w == 15);
        chk("t5_full", 32'(tready), 32'd0);
        tdata = 32'hDEAD_BEEF; tlast = 1'b0; tvalid = 1'b1;
        tick(4);
        tvalid = 1'b0;
        tick(2);
        chk("t5_ovf", 32'(ocnt - o0), 32'd4);
        chk("t5_stalled", 32'(oq.size()), 32'(base));
        rdy_fix = 1'b1;
        wait_n(base + 32, "t5_count");
        for (int i = 0; i < 32; i++) begin
            chk("t5_data", 32'(oq[base+i].d), 32'(16'h0400 + 16'(i ^ 1)));
            chk("t5_flags", 32'(oq[base+i].f),
                32'({i == 0, i == 31, i == 0, i == 31}));
        end
        chk("t5_stable", 32'(viol), 32'd0);

        // illegal sample_num values are dropped
        c0 = ccnt; v0 = vcnt;
        sample_num = 16'd7;
        push(32'h1111_1111, 1'b0);
        push(32'h2222_2222, 1'b0);
        push(32'h3333_3333, 1'b1);
        sample_num = 16'd0;
        push(32'h4444_4444, 1'b1);
        sample_num = 16'd34;
        push(32'h5555_5555, 1'b1);
        tick(6);
        chk("t6_cfg", 32'(ccnt - c0), 32'd3);
        chk("t6_noout", 32'(vcnt - v0), 32'd0);

        // reset in the middle of a chirp
        sample_num = 16'd8;
        push(wd(16'h0500, 0), 1'b0);
        push(wd(16'h0500, 1), 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_data", 32'(m_data), 32'd0);
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_tready", 32'(tready), 32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        base = oq.size();
        for (int w = 0; w < 4; w++) push(wd(16'h0600, w), w == 3);
        wait_n(base + 8, "t6_count");
        for (int i = 0; i < 8; i++) begin
            chk("t6_data", 32'(oq[base+i].d), 32'(16'h0600 + 16'(i ^ 1)));
            chk("t6_flags", 32'(oq[base+i].f), 32'({i == 0, i == 7, i == 0, i == 7}));
            chk("t6_idx", 32'(oq[base+i].ix), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
